// File: rtl/servo_ramp_controller.sv
// Slew-limited servo move sequencer: one position step per STEP_CYCLES, then settle.
// Optional abort input and ABORTADO state enabled by defining SERVO_ABORT_EN.
module servo_ramp_controller #(
   parameter int         STEP_CYCLES   = 5000000,
   parameter int         SETTLE_CYCLES = 25000000,
   parameter logic [2:0] RESET_POS     = 3'b011
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [2:0] destino,
`ifdef SERVO_ABORT_EN
   input  logic       abortar,
`endif
   output logic       pronto,
   output logic [2:0] posicao,
   output logic       movendo,
   output logic       fim,
   output logic [2:0] db_estado
);

   localparam int MAX_CYC = (STEP_CYCLES > SETTLE_CYCLES) ?
                            STEP_CYCLES : SETTLE_CYCLES;
   localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TW-1:0] STEP_LD   = TW'(STEP_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      PASSO    = 3'd1,
      ASSENTA  = 3'd2,
`ifdef SERVO_ABORT_EN
      FIM      = 3'd3,
      ABORTADO = 3'd4
`else
      FIM      = 3'd3
`endif
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [2:0]    pos_q, pos_d;
   logic [2:0]    tgt_q, tgt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [2:0]    pos_nxt;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= OCIOSO;
         pos_q    <= RESET_POS;
         tgt_q    <= RESET_POS;
         tmr_q    <= '0;
      end else begin
         estado_q <= estado_d;
         pos_q    <= pos_d;
         tgt_q    <= tgt_d;
         tmr_q    <= tmr_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      pos_d    = pos_q;
      tgt_d    = tgt_q;
      tmr_d    = tmr_q;
      // pos_q never equals tgt_q in PASSO, so this cannot wrap 7<->0
      pos_nxt  = (tgt_q > pos_q) ? pos_q + 3'd1 : pos_q - 3'd1;

      unique case (estado_q)
         OCIOSO: begin
            if (iniciar) begin
               tgt_d = destino;
               if (destino != pos_q) begin
                  estado_d = PASSO;
                  tmr_d    = STEP_LD;
               end else begin
                  estado_d = FIM;
               end
            end
         end

         PASSO: begin
`ifdef SERVO_ABORT_EN
            if (abortar) begin
               estado_d = ABORTADO;
               tmr_d    = '0;
            end else
`endif
            if (tmr_q == '0) begin
               pos_d = pos_nxt;
               if (pos_nxt == tgt_q) begin
                  estado_d = ASSENTA;
                  tmr_d    = SETTLE_LD;
               end else begin
                  tmr_d    = STEP_LD;
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end

         ASSENTA: begin
`ifdef SERVO_ABORT_EN
            if (abortar) begin
               estado_d = ABORTADO;
               tmr_d    = '0;
            end else
`endif
            if (tmr_q == '0) begin
               estado_d = FIM;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end

         FIM: begin
            estado_d = OCIOSO;
         end

`ifdef SERVO_ABORT_EN
         ABORTADO: begin
            estado_d = FIM;
         end
`endif

         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   assign pronto    = (estado_q == OCIOSO);
   assign movendo   = (estado_q == PASSO) || (estado_q == ASSENTA);
   assign fim       = (estado_q == FIM);
   assign posicao   = pos_q;
   assign db_estado = estado_q;

endmodule

// File: tb/tb_servo_ramp_controller.sv
// Bench for servo_ramp_controller: phase-arithmetic model checked every cycle,
// plus directed moves with literal expectations (STEP=4, SETTLE=6).
module tb_servo_ramp_controller;

   localparam int S = 4;
   localparam int T = 6;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar;
   logic [2:0] destino;
`ifdef SERVO_ABORT_EN
   logic       abortar;
`endif
   logic       pronto;
   logic [2:0] posicao;
   logic       movendo;
   logic       fim;
   logic [2:0] db_estado;

   servo_ramp_controller #(
      .STEP_CYCLES  (S),
      .SETTLE_CYCLES(T),
      .RESET_POS    (3'b011)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .iniciar  (iniciar),
      .destino  (destino),
`ifdef SERVO_ABORT_EN
      .abortar  (abortar),
`endif
      .pronto   (pronto),
      .posicao  (posicao),
      .movendo  (movendo),
      .fim      (fim),
      .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // model: mode 0 idle, 1 moving since edge m_k, 2 aborted, 3 post-abort fim
   int m_mode = 0;
   int m_k    = 0;
   int m_p0   = 3;
   int m_t    = 3;
   int m_ipos = 3;
   int m_apos = 3;

   // state code d edges after the accepting edge
   function automatic int ph_db(input int d, input int p0, input int t);
      int n = (t > p0) ? t - p0 : p0 - t;
      if (n == 0) return 3;
      if (d < n * S) return 1;
      if (d < n * S + T) return 2;
      return 3;
   endfunction

   function automatic int ph_pos(input int d, input int p0, input int t);
      int n  = (t > p0) ? t - p0 : p0 - t;
      int sg = (t > p0) ? 1 : -1;
      if (d < n * S) return p0 + sg * (d / S);
      return t;
   endfunction

   function automatic int e_db();
      case (m_mode)
         0:       return 0;
         1:       return ph_db(cyc - 1 - m_k, m_p0, m_t);
         2:       return 4;
         default: return 3;
      endcase
   endfunction

   function automatic int e_pos();
      case (m_mode)
         0:       return m_ipos;
         1:       return ph_pos(cyc - 1 - m_k, m_p0, m_t);
         default: return m_apos;
      endcase
   endfunction

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (reset) begin
         m_mode <= 0;
         m_ipos <= 3;
      end else begin
         case (m_mode)
            0: begin
               if (iniciar) begin
                  m_mode <= 1;
                  m_k    <= cyc;
                  m_p0   <= m_ipos;
                  m_t    <= int'(destino);
               end
            end
            1: begin
`ifdef SERVO_ABORT_EN
               if (abortar &&
                   ph_db(cyc - 1 - m_k, m_p0, m_t) inside {1, 2}) begin
                  m_mode <= 2;
                  m_apos <= ph_pos(cyc - 1 - m_k, m_p0, m_t);
               end else
`endif
               if (ph_db(cyc - 1 - m_k, m_p0, m_t) == 3) begin
                  m_mode <= 0;
                  m_ipos <= m_t;
               end
            end
            2: m_mode <= 3;
            default: begin
               m_mode <= 0;
               m_ipos <= m_apos;
            end
         endcase
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("db_estado", int'(db_estado), e_db());
         chk("posicao",   int'(posicao),   e_pos());
         chk("pronto",    int'(pronto),    int'(e_db() == 0));
         chk("movendo",   int'(movendo),   int'(e_db() inside {1, 2}));
         chk("fim",       int'(fim),       int'(e_db() == 3));
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic lit(input int p, input int s);
      chk("lit_posicao",   int'(posicao),   p);
      chk("lit_db_estado", int'(db_estado), s);
   endtask

   initial begin
      reset   = 1'b1;
      iniciar = 1'b0;
      destino = 3'd0;
`ifdef SERVO_ABORT_EN
      abortar = 1'b0;
`endif
      edges(2);
      chk_en = 1'b1;
      reset  = 1'b0;
      edges(1);
      lit(3, 0);
      chk("lit_pronto",  int'(pronto),  1);
      chk("lit_movendo", int'(movendo), 0);
      chk("lit_fim",     int'(fim),     0);

      // 3 -> 6, with ignored iniciar/destino during PASSO and ASSENTA
      iniciar = 1'b1;
      destino = 3'd6;
      edges(1);
      iniciar = 1'b0;
      lit(3, 1);
      edges(3);
      lit(3, 1);
      edges(1);
      lit(4, 1);
      destino = 3'd2;
      iniciar = 1'b1;
      edges(1);
      iniciar = 1'b0;
      edges(3);
      lit(5, 1);
      edges(4);
      lit(6, 2);
      iniciar = 1'b1;
      destino = 3'd1;
      edges(5);
      lit(6, 2);
      edges(1);
      lit(6, 3);
      chk("lit_fim", int'(fim), 1);
      iniciar = 1'b0;
      edges(1);
      lit(6, 0);
      chk("lit_pronto", int'(pronto), 1);

      // 6 -> 0, no wrap, then back-to-back zero-distance move
      iniciar = 1'b1;
      destino = 3'd0;
      edges(1);
      iniciar = 1'b0;
      destino = 3'd7;
      edges(4);
      lit(5, 1);
      iniciar = 1'b1;
      edges(2);
      iniciar = 1'b0;
      edges(18);
      lit(0, 2);
      edges(6);
      lit(0, 3);
      iniciar = 1'b1;
      destino = 3'd0;
      edges(1);
      lit(0, 0);
      edges(1);
      lit(0, 3);
      chk("lit_movendo", int'(movendo), 0);
      iniciar = 1'b0;
      edges(1);
      lit(0, 0);
      edges(1);
      chk("lit_pronto", int'(pronto), 1);

      // reset in the middle of PASSO
      iniciar = 1'b1;
      destino = 3'd5;
      edges(1);
      iniciar = 1'b0;
      edges(6);
      lit(1, 1);
      reset = 1'b1;
      edges(1);
      lit(3, 0);
      chk("lit_pronto", int'(pronto), 1);
      reset = 1'b0;
      edges(2);
      lit(3, 0);

      // 3 -> 1 and back to 3
      iniciar = 1'b1;
      destino = 3'd1;
      edges(1);
      iniciar = 1'b0;
      edges(14);
      lit(1, 3);
      iniciar = 1'b1;
      destino = 3'd3;
      edges(1);
      lit(1, 0);
      edges(1);
      iniciar = 1'b0;
      edges(14);
      lit(3, 3);
      edges(1);
      lit(3, 0);

`ifdef SERVO_ABORT_EN
      abortar = 1'b1;
      edges(2);
      lit(3, 0);
      abortar = 1'b0;
      iniciar = 1'b1;
      destino = 3'd7;
      edges(1);
      iniciar = 1'b0;
      edges(4);
      lit(4, 1);
      abortar = 1'b1;
      edges(1);
      lit(4, 4);
      abortar = 1'b0;
      edges(1);
      lit(4, 3);
      chk("lit_fim", int'(fim), 1);
      edges(1);
      lit(4, 0);
`endif

      edges(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
